cache_ctrl: RTL

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_pkg.sv | 29 ++
 rtl/cache_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller and the cache array.
//   - Byte-address field layout: tag 23 | index 5 | word 2 | byte 2.
//   - Controller state encoding (state_e), exported for debug observation.
//   - line_word_addr(): builds a word-aligned byte address from line + word.
package cache_ctrl_pkg;

    localparam int TAG_W   = 23;
    localparam int IDX_W   = 5;
    localparam int WORD_W  = 2;
    localparam int BYTE_W  = 2;
    localparam int IDX_LSB = WORD_W + BYTE_W;   // 4
    localparam int TAG_LSB = IDX_LSB + IDX_W;   // 9
    localparam int LINE_W  = TAG_W + IDX_W;     // line number width (28)

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TAG     = 3'd1,
        ST_BACK_RD = 3'd2,
        ST_BACK_WR = 3'd3,
        ST_FILL    = 3'd4,
        ST_REPLAY  = 3'd5
    } state_e;

    function automatic logic [31:0] line_word_addr(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] word);
        return {line, word, {BYTE_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Write-back cache controller sitting between a CPU port, a cache array with
// registered (1-cycle) outputs, and a word-wide memory with an ack handshake.
//
// Ports
//   clk, rst               : single clock, synchronous active-high reset
//   en_r, en_w             : CPU read / write request, held while stall is high
//   addr, u_b_h_w, data_w  : CPU byte address, access width/sign, write data
//   data_r, stall          : CPU read data, hold-request indication
//   cache_addr, cache_din  : address / data to cache array
//   cache_load/edit/store  : cache read / CPU write / line-fill word write
//   cache_invalid          : tied low
//   cache_u_b_h_w          : u_b_h_w forwarded unchanged to the cache array
//   cache_hit/valid/dirty/tag/dout : registered cache responses (victim way info)
//   mem_cs, mem_we, mem_addr, mem_dout, mem_din, mem_ack : memory port
//   dbg_state              : current controller state
//
// Memory handshake: while mem_cs is high the controller holds mem_we, mem_addr
// and mem_dout stable; a cycle with mem_ack high transfers exactly one word and
// the controller moves on in that same cycle. mem_ack is ignored when mem_cs
// is low.
//
// The address field slicing assumes the 32-bit layout of cache_ctrl_pkg.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_BITS  = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic [31:0]          cache_din,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic                 cache_invalid,
    output logic [2:0]           cache_u_b_h_w,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_W-1:0]     cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_dout,
    input  logic [31:0]          mem_din,
    input  logic                 mem_ack,
    output state_e               dbg_state
);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  wcnt_q, wcnt_d;
    logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
    logic [31:0]        data_r_q, data_r_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               wb_fresh_q, wb_fresh_d;

    logic               req;
    logic               rd_only;
    logic [31:0]        fill_addr;
    logic [31:0]        wb_addr;

    assign req       = en_r | en_w;
    assign rd_only   = en_r & ~en_w;    // read+write together behaves as a write
    assign fill_addr = line_word_addr(addr[ADDR_BITS-1:IDX_LSB], wcnt_q);
    assign wb_addr   = line_word_addr({victim_tag_q, addr[TAG_LSB-1:IDX_LSB]}, wcnt_q);

    assign stall         = req & ~((state_q == ST_TAG) & cache_hit);
    assign data_r        = data_r_q;
    assign cache_invalid = 1'b0;
    assign cache_u_b_h_w = u_b_h_w;
    assign dbg_state     = state_q;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        victim_tag_d = victim_tag_q;
        data_r_d     = data_r_q;
        wb_data_d    = wb_data_q;
        wb_fresh_d   = wb_fresh_q;
        cache_addr   = addr;
        cache_din    = data_w;
        cache_load   = 1'b0;
        cache_edit   = 1'b0;
        cache_store  = 1'b0;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = fill_addr;
        mem_dout     = wb_data_q;

        unique case (state_q)
            ST_IDLE, ST_REPLAY: begin
                if (req) begin
                    cache_load = rd_only;
                    cache_edit = en_w;
                    state_d    = ST_TAG;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_TAG: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cache_hit) begin
                    if (rd_only) data_r_d = cache_dout;
                    state_d = ST_IDLE;
                end else begin
                    victim_tag_d = cache_tag;
                    wcnt_d       = '0;
                    state_d      = (cache_valid & cache_dirty) ? ST_BACK_RD : ST_FILL;
                end
            end
            ST_BACK_RD: begin
                // Victim word is read from the same set; data appears next cycle.
                cache_addr = fill_addr;
                wb_fresh_d = 1'b1;
                state_d    = ST_BACK_WR;
            end
            ST_BACK_WR: begin
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wb_addr;
                // cache_dout is only valid in the first BACK_WR cycle; latch it so
                // mem_dout stays constant however long the memory takes.
                if (wb_fresh_q) begin
                    mem_dout   = cache_dout;
                    wb_data_d  = cache_dout;
                    wb_fresh_d = 1'b0;
                end
                if (mem_ack) begin
                    wcnt_d  = wcnt_q + 1'b1;
                    state_d = (wcnt_q == LAST_WORD) ? ST_FILL : ST_BACK_RD;
                end
            end
            ST_FILL: begin
                mem_cs = 1'b1;
                if (mem_ack) begin
                    cache_store = 1'b1;
                    cache_addr  = fill_addr;
                    cache_din   = mem_din;
                    wcnt_d      = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_WORD) state_d = ST_REPLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing leaves the controller while reset is held.
        if (rst) begin
            cache_load  = 1'b0;
            cache_edit  = 1'b0;
            cache_store = 1'b0;
            mem_cs      = 1'b0;
            mem_we      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            victim_tag_q <= '0;
            data_r_q     <= '0;
            wb_data_q    <= '0;
            wb_fresh_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            victim_tag_q <= victim_tag_d;
            data_r_q     <= data_r_d;
            wb_data_q    <= wb_data_d;
            wb_fresh_q   <= wb_fresh_d;
        end
    end

endmodule
